// File: rtl/divider_16bit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a
// start/done handshake, with an explicit divide-by-zero result.
module divider_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_reg;   // partial remainder; always < divisor between iterations
    logic [WIDTH-1:0] work;      // dividend bits shift out as quotient bits shift in
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_work;

    // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        shifted   = {rem_reg, work[WIDTH-1]};
        trial     = shifted - {1'b0, dvsr};
        q_bit     = ~trial[WIDTH];
        next_rem  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        next_work = {work[WIDTH-2:0], q_bit};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem_reg     <= '0;
            work        <= '0;
            dvsr        <= '0;
            count       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        dvsr <= divisor;
                        work <= dividend;
                        if (divisor != '0) begin
                            rem_reg <= '0;
                            count   <= '0;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                RUN: begin
                    rem_reg <= next_rem;
                    work    <= next_work;
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        quotient    <= next_work;
                        remainder   <= next_rem;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_16bit.sv
// Self-checking bench for divider_16bit: directed cases from the test plan plus
// randomized divides compared against plain '/' and '%' arithmetic.
module tb_divider_16bit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;
    logic         prev_z = 1'b0;

    divider_16bit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request during cycle 0; returns #1 into cycle 1 with operands scrambled.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Walk cycles 1..latency checking handshake and held outputs; ends inside the done cycle.
    task automatic expect_result(input logic [W-1:0] a, input logic [W-1:0] b, input int inject_cycle);
        int           lat;
        logic [W-1:0] eq, er;
        logic         ez;
        ez  = (b == '0);
        eq  = ez ? '1 : a / b;
        er  = ez ? a : a % b;
        lat = ez ? 1 : W + 1;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            if (cyc < lat) begin
                check($sformatf("busy_c%0d", cyc), busy, 1'b1);
                check($sformatf("done_c%0d", cyc), done, 1'b0);
                check($sformatf("held_q_c%0d", cyc), quotient, prev_q);
                check($sformatf("held_r_c%0d", cyc), remainder, prev_r);
                if (cyc == inject_cycle) begin
                    start    = 1'b1;
                    dividend = 16'd9;
                    divisor  = 16'd2;
                end else if (cyc == inject_cycle + 1) begin
                    start = 1'b0;
                end
                step();
            end else begin
                check("busy_at_done", busy, 1'b0);
                check("done", done, 1'b1);
                check("quotient", quotient, eq);
                check("remainder", remainder, er);
                check("div_by_zero", div_by_zero, ez);
            end
        end
        start  = 1'b0;
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
    endtask

    task automatic idle_after();
        step();
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_q", quotient, prev_q);
        check("idle_z", div_by_zero, prev_z);
    endtask

    initial begin
        logic [W-1:0] ra, rb;

        // Reset state
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q", quotient, 16'h0);
        check("rst_r", remainder, 16'h0);
        check("rst_z", div_by_zero, 1'b0);
        step();
        rst_n = 1'b1;

        // 100 / 7
        launch(16'd100, 16'd7);
        expect_result(16'd100, 16'd7, 0);
        idle_after();

        // 0xFFFF / 1, then 3 / 10
        launch(16'hFFFF, 16'd1);
        expect_result(16'hFFFF, 16'd1, 0);
        idle_after();
        launch(16'd3, 16'd10);
        expect_result(16'd3, 16'd10, 0);
        idle_after();

        // Divide by zero: done in cycle 1, busy never high
        launch(16'h1234, 16'd0);
        expect_result(16'h1234, 16'd0, 0);
        idle_after();

        // Start during busy ignored
        launch(16'd50, 16'd5);
        expect_result(16'd50, 16'd5, 4);
        idle_after();

        // Back-to-back: second start issued in the DONE cycle
        launch(16'h8000, 16'h0003);
        expect_result(16'h8000, 16'h0003, 0);
        launch(16'd7, 16'd7);
        expect_result(16'd7, 16'd7, 0);
        idle_after();

        // Reset in cycle 8 aborts the divide
        launch(16'hABCD, 16'h0013);
        repeat (7) step();
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_q", quotient, 16'h0);
        check("abort_r", remainder, 16'h0);
        check("abort_z", div_by_zero, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", done, 1'b0);
        end
        rst_n  = 1'b1;
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
        launch(16'd20, 16'd6);
        expect_result(16'd20, 16'd6, 0);
        idle_after();

        // Randomized divides, mixing idle gaps and back-to-back starts
        for (int n = 0; n < 30; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            launch(ra, rb);
            expect_result(ra, rb, 0);
            if ($urandom_range(0, 1) == 0) idle_after();
        end
        idle_after();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_16bit.md
# divider_16bit

Multi-cycle unsigned restoring divider for the datapath, built on the same add/sub arithmetic as the ALU adders. Each iteration does a trial subtraction of the divisor from the shifted partial remainder and produces one quotient bit per cycle. Behind a start/done handshake it produces quotient and remainder from a captured dividend and divisor. It sits beside the ALU as the long-latency divide unit; the core stalls on `busy`.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width; must be at least 2.

- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `start`  input  1: request a divide; accepted only while `busy` = 0.
- `dividend`  input  WIDTH: unsigned dividend; sampled on the accepting edge.
- `divisor`  input  WIDTH: unsigned divisor; sampled on the accepting edge.
- `busy`  output  1: high while an accepted divide is iterating.
- `done`  output  1: one-cycle pulse; `quotient`, `remainder` and `div_by_zero` are valid from this cycle on.
- `quotient`  output  WIDTH: result quotient; held until the next completion.
- `remainder`  output  WIDTH: result remainder; held until the next completion.
- `div_by_zero`  output  1: set with `done` when the captured divisor was 0; held until the next completion.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - `start` = 1 captures the operands into internal registers.
  - Divisor nonzero: clear the partial remainder (WIDTH+1 bits) and the iteration counter, then go to RUN.
  - Divisor zero: go to DONE directly.
- RUN, one iteration per edge:
  - Shift left {partial remainder, working dividend} by 1.
  - Trial = partial remainder − divisor, computed at WIDTH+1 bits.
  - Trial non-negative (MSB = 0): partial remainder ← trial, quotient LSB ← 1.
  - Otherwise: restore (keep the shifted value), quotient LSB ← 0.
  - Counter increments. On iteration WIDTH, register the results into the output registers and go to DONE.
- DONE
  - Lasts exactly one cycle: `done` = 1, `busy` = 0.
  - Next state is IDLE, unless `start` = 1 in this cycle; that start is accepted exactly as in IDLE (back-to-back operation).
- Divide by zero: `quotient` = all ones, `remainder` = captured dividend, `div_by_zero` = 1.
- Normal result: `div_by_zero` = 0, `quotient` = floor(dividend/divisor), `remainder` = dividend mod divisor.
- Output registers change only on the edge that enters DONE. While RUN is in progress they show the previous result.
- Operand input changes after the accepting edge have no effect.
- `start` while `busy` = 1 is ignored: no queuing, no restart.
- Arithmetic is unsigned only. The partial remainder needs WIDTH+1 bits so the subtract borrow is visible.

## Timing
- Count the cycle in which `start` is sampled high as cycle 0.
  - Nonzero divisor: `busy` = 1 in cycles 1..WIDTH; `done` = 1 in cycle WIDTH+1 (cycle 17 for WIDTH = 16). Latency is WIDTH+1 cycles.
  - Zero divisor: `busy` never asserts; `done` = 1 in cycle 1.
- Back-to-back: a start in the DONE cycle gives `busy` = 1 in the following cycle. Throughput is one result per WIDTH+1 cycles.
- Reset values, applied immediately and asynchronously when `rst_n` goes low:
  - state IDLE
  - `busy` = 0, `done` = 0, `div_by_zero` = 0
  - `quotient` = 0, `remainder` = 0
  - counter and internal registers cleared
- Reset during RUN aborts the operation. No `done` is produced, and the previous results are lost.
- The first edge after `rst_n` rises may accept `start`.
- `busy` and `done` are never high in the same cycle.

## Test plan
- 100 / 7 with WIDTH = 16, start in cycle 0 -> `busy` high in cycles 1–16; `done` in cycle 17 with `quotient` = 14, `remainder` = 2, `div_by_zero` = 0.
- 0xFFFF / 1 -> `quotient` = 0xFFFF, `remainder` = 0; then 3 / 10 -> `quotient` = 0, `remainder` = 3.
- 0x1234 / 0 -> `done` in cycle 1; `quotient` = 0xFFFF, `remainder` = 0x1234, `div_by_zero` = 1; `busy` never high.
- Start 50 / 5; in cycle 4 drive `start` = 1 with 9 / 2 and change the operand inputs -> second request ignored; `done` in cycle 17 with `quotient` = 10, `remainder` = 0.
- Back-to-back: 0x8000 / 0x0003, then `start` in its DONE cycle with 7 / 7 -> first result `quotient` = 0x2AAA, `remainder` = 2; second `done` 17 cycles later with `quotient` = 1, `remainder` = 0.
- Pull `rst_n` low in cycle 8 of a divide -> all outputs 0 immediately, no `done`; after release a new 20 / 6 gives `quotient` = 3, `remainder` = 2.
